// File: rtl/button_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// button_debouncer_pkg
// Shared types and helpers for the push-button debouncer.
//   btn_state_t   : debounce FSM states
//   us_to_cycles  : converts a time in microseconds to a cycle count at a given
//                   clock frequency, floored at 1 cycle, in 64-bit arithmetic
// -----------------------------------------------------------------------------
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Product is formed in 64 bits so large frequencies times long intervals
  // cannot overflow; a result of 0 is promoted to 1 so counters stay valid.
  function automatic logic [63:0] us_to_cycles(input logic [31:0] freq,
                                               input logic [31:0] us);
    logic [63:0] cycles;
    cycles = ({32'd0, freq} * {32'd0, us}) / 64'd1_000_000;
    if (cycles == 64'd0) begin
      cycles = 64'd1;
    end
    return cycles;
  endfunction

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Single-bit two-flop synchronizer for asynchronous pin inputs.
// Ports:
//   i_clk  : destination clock
//   i_rst  : synchronous active-high reset, loads RESET_VAL into both flops
//   i_d    : asynchronous input
//   o_q    : synchronized output (two cycles of latency)
// Parameters:
//   RESET_VAL : value both flops take in reset
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Turns a raw, bouncing push-button pin into a clean debounced level plus
// one-cycle press/release strobes. The pin is synchronized with sync_2ff, then
// a 4-state FSM requires D consecutive stable cycles before accepting a change.
// Ports:
//   i_clk     : clock
//   i_rst     : synchronous active-high reset
//   i_btn     : raw asynchronous pin
//   o_level   : debounced pressed level (1 = pressed)
//   o_press   : one-cycle strobe when a press is accepted
//   o_release : one-cycle strobe when a release is accepted
//   o_long    : one-cycle strobe once per press after the long-press hold time
// Parameters:
//   CLOCK_FREQ, DEBOUNCE_US, ACTIVE_LOW, LONG_PRESS_US
// Build option:
//   BUTTON_DEBOUNCER_LONG_PRESS_EN : when defined, enables the long-press
//   counter and o_long; otherwise o_long is tied to 0.
// -----------------------------------------------------------------------------
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter logic [31:0] CLOCK_FREQ    = 32'd1_000_000,
  parameter logic [31:0] DEBOUNCE_US   = 32'd10_000,
  parameter logic        ACTIVE_LOW    = 1'b0,
  parameter logic [31:0] LONG_PRESS_US = 32'd1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam logic [63:0] D64    = us_to_cycles(CLOCK_FREQ, DEBOUNCE_US);
  localparam int          CW     = $clog2(D64 + 64'd1);
  localparam logic [CW-1:0] D_LAST = CW'(D64 - 64'd1);

  // Normalize polarity before synchronizing so everything downstream treats
  // 1 as pressed.
  logic w_raw;
  logic w_s;
  assign w_raw = i_btn ^ ACTIVE_LOW;

  sync_2ff #(
    .RESET_VAL (1'b0)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (w_raw),
    .o_q   (w_s)
  );

  btn_state_t    r_state;
  btn_state_t    w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_level;
  logic          w_level_next;
  logic          r_press;
  logic          w_press_next;
  logic          r_release;
  logic          w_release_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= RELEASED;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_level   <= w_level_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
    end
  end

  // The first cycle with the new value moves into a WAIT state with cnt=0;
  // the WAIT state then needs D more matching cycles (cnt 0..D-1) to commit.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_level_next   = r_level;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_s) begin
          w_state_next = PRESS_WAIT;
          w_cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_s) begin
          w_state_next = RELEASED;
        end else if (r_cnt == D_LAST) begin
          w_state_next = PRESSED;
          w_press_next = 1'b1;
          w_level_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!w_s) begin
          w_state_next = RELEASE_WAIT;
          w_cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_s) begin
          w_state_next = PRESSED;
        end else if (r_cnt == D_LAST) begin
          w_state_next   = RELEASED;
          w_release_next = 1'b1;
          w_level_next   = 1'b0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_next = RELEASED;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam logic [63:0] L64    = us_to_cycles(CLOCK_FREQ, LONG_PRESS_US);
  localparam int          LW     = $clog2(L64 + 64'd1);
  localparam logic [LW-1:0] L_LAST = LW'(L64 - 64'd1);
  localparam logic [LW-1:0] L_MAX  = LW'(L64);

  logic [LW-1:0] r_lcnt;
  logic [LW-1:0] w_lcnt_next;
  logic          r_long;
  logic          w_long_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lcnt <= '0;
      r_long <= 1'b0;
    end else begin
      r_lcnt <= w_lcnt_next;
      r_long <= w_long_next;
    end
  end

  // lcnt climbs to L and stays there; the strobe fires only on the single
  // step from L-1 to L, which makes it once-per-press. A silent return from
  // RELEASE_WAIT to PRESSED is the same press, so it does not clear lcnt.
  always_comb begin
    w_lcnt_next = r_lcnt;
    w_long_next = 1'b0;
    if (w_press_next) begin
      w_lcnt_next = '0;
    end else if (((r_state == PRESSED) || (r_state == RELEASE_WAIT)) &&
                 (r_lcnt != L_MAX)) begin
      w_lcnt_next = r_lcnt + LW'(1);
      if (r_lcnt == L_LAST) begin
        w_long_next = 1'b1;
      end
    end
  end

  assign o_long = r_long;
`else
  // Long-press hold time is only meaningful with the feature built in.
  logic w_unused_long_cfg;
  assign w_unused_long_cfg = ^LONG_PRESS_US;
  assign o_long = 1'b0;
`endif

endmodule
